// File: rtl/smi_write_frame_arbiter_if.sv
// smi_write_frame_arbiter_if
// Bundles the per-port requester links and the shared downstream SMI links
// of the write frame arbiter. The arbiter takes the slave view, the
// surrounding requesters / write adaptor take the master view.
//
// Handshake: a word moves across a link on a rising clk edge where
// Ready=1 and Stop=0. The sender holds Ready, Eofc and Data stable until
// that edge. Eofc != 0 marks the last word of a frame. Eofc and Data are
// don't-care whenever Ready=0.
interface smi_write_frame_arbiter_if #(
    parameter int DataWidth = 128,
    parameter int NumPorts  = 4
);
    logic [NumPorts-1:0]           portReqReady;
    logic [8*NumPorts-1:0]         portReqEofc;
    logic [DataWidth*NumPorts-1:0] portReqData;
    logic [NumPorts-1:0]           portReqStop;

    logic [NumPorts-1:0]           portRespReady;
    logic [8*NumPorts-1:0]         portRespEofc;
    logic [DataWidth*NumPorts-1:0] portRespData;
    logic [NumPorts-1:0]           portRespStop;

    logic                          smiReqReady;
    logic [7:0]                    smiReqEofc;
    logic [DataWidth-1:0]          smiReqData;
    logic                          smiReqStop;

    logic                          smiRespReady;
    logic [7:0]                    smiRespEofc;
    logic [DataWidth-1:0]          smiRespData;
    logic                          smiRespStop;

    // Request FSM state: 0 = ArbIdle, 1 = ArbHeader, 2 = ArbBody.
    logic [1:0]                    dbgArbState;

    modport slave (
        input  portReqReady, portReqEofc, portReqData, portRespStop,
        input  smiReqStop, smiRespReady, smiRespEofc, smiRespData,
        output portReqStop, portRespReady, portRespEofc, portRespData,
        output smiReqReady, smiReqEofc, smiReqData, smiRespStop,
        output dbgArbState
    );

    modport master (
        output portReqReady, portReqEofc, portReqData, portRespStop,
        output smiReqStop, smiRespReady, smiRespEofc, smiRespData,
        input  portReqStop, portRespReady, portRespEofc, portRespData,
        input  smiReqReady, smiReqEofc, smiReqData, smiRespStop,
        input  dbgArbState
    );
endinterface

// File: rtl/smi_write_frame_arbiter.sv
// smi_write_frame_arbiter
// Shares one SMI write request channel between NumPorts requesters, one
// whole frame at a time. The granted port index is stamped into header
// bits [31:24] on the way down; response frames are routed back to the port
// named by header bits [26:24], with bits [31:24] of the header cleared.
// Out-of-range response routes are consumed and dropped.
//
// Build option: define SMI_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// without it the lowest requesting port index wins.
module smi_write_frame_arbiter #(
    parameter int DataIndexSize = 4,
    parameter int NumPorts      = 4
) (
    input  logic                    clk,
    input  logic                    srst,
    smi_write_frame_arbiter_if.slave bus
);
    localparam int DataWidth = 8 * (2 ** DataIndexSize);
    localparam int IdxW      = $clog2(NumPorts);

    typedef enum logic [1:0] {
        ArbIdle   = 2'd0,
        ArbHeader = 2'd1,
        ArbBody   = 2'd2
    } arb_state_t;

    // Request path state
    arb_state_t           state_q, state_d;
    logic [IdxW-1:0]      grant_q, grant_d;
    logic                 req_full_q, req_full_d;
    logic [7:0]           req_eofc_q, req_eofc_d;
    logic [DataWidth-1:0] req_data_q, req_data_d;
`ifdef SMI_ARB_ROUND_ROBIN_EN
    localparam int CW = IdxW + 1;
    logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]        cand;
    logic                 found;
`endif

    // Response path state
    logic                 resp_full_q, resp_full_d;
    logic [7:0]           resp_eofc_q, resp_eofc_d;
    logic [DataWidth-1:0] resp_data_q, resp_data_d;
    logic [2:0]           route_q, route_d;
    logic                 resp_sof_q, resp_sof_d;

    // Combinational helpers
    logic [IdxW-1:0]      winner;
    logic                 sel_ready;
    logic [7:0]           sel_eofc;
    logic [DataWidth-1:0] sel_data;
    logic [NumPorts-1:0]  port_req_stop;
    logic                 resp_accept;
    logic                 resp_route_stop;
    logic [2:0]           word_route;

    // Choose the next frame owner among ports presenting a word.
    always_comb begin
        winner = '0;
`ifdef SMI_ARB_ROUND_ROBIN_EN
        // First requester at or after the pointer, wrapping past the top port.
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NumPorts; i++) begin
            cand = {1'b0, rr_ptr_q} + CW'(i);
            if (cand >= CW'(NumPorts)) cand = cand - CW'(NumPorts);
            if (!found && bus.portReqReady[cand[IdxW-1:0]]) begin
                winner = cand[IdxW-1:0];
                found  = 1'b1;
            end
        end
`else
        // Scan downwards so the lowest requesting index is the last write.
        for (int i = NumPorts - 1; i >= 0; i--) begin
            if (bus.portReqReady[i]) winner = IdxW'(i);
        end
`endif
    end

    // Mux the granted port's request link.
    always_comb begin
        sel_ready = 1'b0;
        sel_eofc  = '0;
        sel_data  = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (grant_q == IdxW'(i)) begin
                sel_ready = bus.portReqReady[i];
                sel_eofc  = bus.portReqEofc[8*i +: 8];
                sel_data  = bus.portReqData[DataWidth*i +: DataWidth];
            end
        end
    end

    // Request FSM next state, grant, output buffer fill/drain.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        req_full_d    = req_full_q;
        req_eofc_d    = req_eofc_q;
        req_data_d    = req_data_q;
`ifdef SMI_ARB_ROUND_ROBIN_EN
        rr_ptr_d      = rr_ptr_q;
`endif
        port_req_stop = '1;

        // Buffer empties on a downstream transfer; Stop stays high that cycle.
        if (req_full_q && !bus.smiReqStop) req_full_d = 1'b0;

        case (state_q)
            ArbIdle: begin
                if (|bus.portReqReady) begin
                    grant_d = winner;
                    state_d = ArbHeader;
`ifdef SMI_ARB_ROUND_ROBIN_EN
                    rr_ptr_d = (winner == IdxW'(NumPorts - 1)) ? '0 : winner + 1'b1;
`endif
                end
            end
            ArbHeader, ArbBody: begin
                for (int i = 0; i < NumPorts; i++) begin
                    if (grant_q == IdxW'(i)) port_req_stop[i] = req_full_q;
                end
                if (sel_ready && !req_full_q) begin
                    req_full_d = 1'b1;
                    req_eofc_d = sel_eofc;
                    req_data_d = sel_data;
                    // Header tag[15:8] carries the source port downstream.
                    if (state_q == ArbHeader) req_data_d[31:24] = 8'(grant_q);
                    state_d = (sel_eofc != 8'd0) ? ArbIdle : ArbBody;
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    // Response routing: latch route on the first word, drop unknown routes.
    always_comb begin
        resp_full_d     = resp_full_q;
        resp_eofc_d     = resp_eofc_q;
        resp_data_d     = resp_data_q;
        route_d         = route_q;
        resp_sof_d      = resp_sof_q;
        resp_route_stop = 1'b0;
        word_route      = route_q;
        resp_accept     = bus.smiRespReady && !resp_full_q;

        for (int i = 0; i < NumPorts; i++) begin
            if (route_q == 3'(i)) resp_route_stop = bus.portRespStop[i];
        end
        if (resp_full_q && !resp_route_stop) resp_full_d = 1'b0;

        if (resp_accept) begin
            word_route  = resp_sof_q ? bus.smiRespData[26:24] : route_q;
            route_d     = word_route;
            resp_sof_d  = (bus.smiRespEofc != 8'd0);
            resp_eofc_d = bus.smiRespEofc;
            resp_data_d = bus.smiRespData;
            // Only the header carries the tag; body words pass through as-is.
            if (resp_sof_q) resp_data_d[31:24] = 8'h00;
            // Out-of-range words are consumed without ever filling the buffer.
            resp_full_d = ({1'b0, word_route} < 4'(NumPorts));
        end
    end

    // Drive per-port response valids from the buffered word's route.
    always_comb begin
        bus.portRespReady = '0;
        for (int i = 0; i < NumPorts; i++) begin
            bus.portRespReady[i] = resp_full_q && (route_q == 3'(i));
        end
    end

    assign bus.portReqStop  = port_req_stop;
    assign bus.smiReqReady  = req_full_q;
    assign bus.smiReqEofc   = req_eofc_q;
    assign bus.smiReqData   = req_data_q;
    assign bus.smiRespStop  = resp_full_q;
    assign bus.portRespEofc = {NumPorts{resp_eofc_q}};
    assign bus.portRespData = {NumPorts{resp_data_q}};
    assign bus.dbgArbState  = state_q;

    // Register the request FSM, both single-entry buffers and routing state.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= ArbIdle;
            grant_q     <= '0;
            req_full_q  <= 1'b0;
            req_eofc_q  <= '0;
            req_data_q  <= '0;
`ifdef SMI_ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= '0;
`endif
            resp_full_q <= 1'b0;
            resp_eofc_q <= '0;
            resp_data_q <= '0;
            route_q     <= '0;
            resp_sof_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            req_full_q  <= req_full_d;
            req_eofc_q  <= req_eofc_d;
            req_data_q  <= req_data_d;
`ifdef SMI_ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
            resp_full_q <= resp_full_d;
            resp_eofc_q <= resp_eofc_d;
            resp_data_q <= resp_data_d;
            route_q     <= route_d;
            resp_sof_q  <= resp_sof_d;
        end
    end
endmodule

// File: tb/tb_smi_write_frame_arbiter.sv
// tb_smi_write_frame_arbiter
// Directed bench for smi_write_frame_arbiter (DataWidth 32, 4 ports).
// Expected grant orders follow SMI_ARB_ROUND_ROBIN_EN when it is defined.
module tb_smi_write_frame_arbiter;
    localparam int DIS = 2;
    localparam int DW  = 8 * (2 ** DIS);
    localparam int NP  = 4;

    typedef struct {
        int          port;
        int          nwords;
        logic [31:0] hdr;
        logic [7:0]  eofc;
        logic [31:0] exp_hdr;
    } req_vec_t;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  eofc;
        logic [3:0]  exp_ready;
        logic [31:0] exp_data;
    } resp_vec_t;

    logic clk;
    logic srst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [DW-1:0] exp_q[$];
    logic [7:0]    exp_eofc_q[$];
    logic [DW-1:0] obs_q[$];
    logic [7:0]    obs_eofc_q[$];
    int            obs_cyc_q[$];

    smi_write_frame_arbiter_if #(.DataWidth(DW), .NumPorts(NP)) bus ();

    smi_write_frame_arbiter #(.DataIndexSize(DIS), .NumPorts(NP)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every downstream request transfer.
    always @(negedge clk) begin
        if (!srst && bus.smiReqReady && !bus.smiReqStop) begin
            obs_q.push_back(bus.smiReqData);
            obs_eofc_q.push_back(bus.smiReqEofc);
            obs_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] body_word(input int p, input int w);
        return DW'(32'hC0DE_0000 + 32'(p * 256 + w));
    endfunction

    // Drive one request frame on port p, word by word, honouring Stop.
    task automatic send_frame(input int p, input int n, input logic [DW-1:0] hdr, input logic [7:0] eofc);
        int   w;
        int   guard;
        logic go;
        w = 0;
        guard = 0;
        while (w < n && guard < 200) begin
            bus.portReqReady[p]       = 1'b1;
            bus.portReqData[p*DW +: DW] = (w == 0) ? hdr : body_word(p, w);
            bus.portReqEofc[p*8 +: 8] = (w == n - 1) ? eofc : 8'h00;
            @(negedge clk);
            go = !bus.portReqStop[p];
            @(posedge clk);
            #1;
            if (go) w++;
            guard++;
        end
        bus.portReqReady[p]       = 1'b0;
        bus.portReqEofc[p*8 +: 8] = 8'h00;
        check($sformatf("send_p%0d_words", p), 64'(w), 64'(n));
    endtask

    task automatic expect_frame(input int p, input int n, input logic [DW-1:0] exp_hdr, input logic [7:0] eofc);
        for (int w = 0; w < n; w++) begin
            exp_q.push_back((w == 0) ? exp_hdr : body_word(p, w));
            exp_eofc_q.push_back((w == n - 1) ? eofc : 8'h00);
        end
    endtask

    task automatic compare_queues(input string name);
        logic [DW-1:0] d;
        logic [DW-1:0] ed;
        logic [7:0]    e;
        logic [7:0]    ee;
        int            k;
        check({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        k = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            d  = obs_q.pop_front();
            ed = exp_q.pop_front();
            e  = obs_eofc_q.pop_front();
            ee = exp_eofc_q.pop_front();
            check($sformatf("%s_w%0d_data", name, k), 64'(d), 64'(ed));
            check($sformatf("%s_w%0d_eofc", name, k), 64'(e), 64'(ee));
            k++;
        end
        exp_q.delete();
        exp_eofc_q.delete();
        obs_q.delete();
        obs_eofc_q.delete();
        obs_cyc_q.delete();
    endtask

    // Offer one response word and wait until it is taken.
    task automatic send_resp(input logic [DW-1:0] d, input logic [7:0] e);
        int   guard;
        logic go;
        guard = 0;
        go = 1'b0;
        bus.smiRespReady = 1'b1;
        bus.smiRespData  = d;
        bus.smiRespEofc  = e;
        while (!go && guard < 50) begin
            @(negedge clk);
            go = !bus.smiRespStop;
            @(posedge clk);
            #1;
            guard++;
        end
        bus.smiRespReady = 1'b0;
        bus.smiRespEofc  = 8'h00;
        check("resp_accept", 64'(go), 64'd1);
    endtask

    task automatic pulse_reset();
        srst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
    endtask

    req_vec_t  qv[4];
    resp_vec_t rv[6];
    int        g;
    logic      go;

    initial begin
        qv[0] = '{port: 1, nwords: 3, hdr: 32'hAB12_3456, eofc: 8'h04, exp_hdr: 32'h0112_3456};
        qv[1] = '{port: 0, nwords: 2, hdr: 32'hFF00_1111, eofc: 8'h01, exp_hdr: 32'h0000_1111};
        qv[2] = '{port: 3, nwords: 1, hdr: 32'h5A5A_5A5A, eofc: 8'h80, exp_hdr: 32'h035A_5A5A};
        qv[3] = '{port: 2, nwords: 4, hdr: 32'h07AA_0000, eofc: 8'h02, exp_hdr: 32'h02AA_0000};

        rv[0] = '{data: 32'h0312_3456, eofc: 8'h04, exp_ready: 4'b1000, exp_data: 32'h0012_3456};
        rv[1] = '{data: 32'hAA00_BEEF, eofc: 8'h01, exp_ready: 4'b0100, exp_data: 32'h0000_BEEF};
        rv[2] = '{data: 32'h0000_0001, eofc: 8'h01, exp_ready: 4'b0001, exp_data: 32'h0000_0001};
        rv[3] = '{data: 32'h0600_0042, eofc: 8'h01, exp_ready: 4'b0000, exp_data: 32'h0000_0000};
        rv[4] = '{data: 32'h0400_0042, eofc: 8'h01, exp_ready: 4'b0000, exp_data: 32'h0000_0000};
        rv[5] = '{data: 32'h0155_0000, eofc: 8'h02, exp_ready: 4'b0010, exp_data: 32'h0055_0000};

        srst = 1'b1;
        bus.portReqReady = '0;
        bus.portReqEofc  = '0;
        bus.portReqData  = '0;
        bus.portRespStop = '0;
        bus.smiReqStop   = 1'b0;
        bus.smiRespReady = 1'b0;
        bus.smiRespEofc  = '0;
        bus.smiRespData  = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_port_req_stop", 64'(bus.portReqStop), 64'hF);
        check("rst_smi_req_ready", 64'(bus.smiReqReady), 64'd0);
        check("rst_port_resp_ready", 64'(bus.portRespReady), 64'd0);
        check("rst_smi_resp_stop", 64'(bus.smiRespStop), 64'd0);
        check("rst_state", 64'(bus.dbgArbState), 64'd0);
        @(posedge clk);
        #1;
        srst = 1'b0;

        // Single-port frames from the table
        for (int v = 0; v < 4; v++) begin
            expect_frame(qv[v].port, qv[v].nwords, qv[v].exp_hdr, qv[v].eofc);
            send_frame(qv[v].port, qv[v].nwords, qv[v].hdr, qv[v].eofc);
            repeat (3) @(posedge clk);
            #1;
            if (v == 0 && obs_cyc_q.size() == 3) begin
                check("req0_gap_1", 64'(obs_cyc_q[1] - obs_cyc_q[0]), 64'd2);
                check("req0_gap_2", 64'(obs_cyc_q[2] - obs_cyc_q[1]), 64'd2);
            end
            check($sformatf("req%0d_idle", v), 64'(bus.dbgArbState), 64'd0);
            compare_queues($sformatf("req%0d", v));
        end

        // Ports 0 and 2 contending with two 2-word frames each
        pulse_reset();
`ifdef SMI_ARB_ROUND_ROBIN_EN
        expect_frame(0, 2, 32'h0000_0000, 8'h01);
        expect_frame(2, 2, 32'h0200_0200, 8'h01);
        expect_frame(0, 2, 32'h0000_0001, 8'h01);
        expect_frame(2, 2, 32'h0200_0201, 8'h01);
`else
        expect_frame(0, 2, 32'h0000_0000, 8'h01);
        expect_frame(0, 2, 32'h0000_0001, 8'h01);
        expect_frame(2, 2, 32'h0200_0200, 8'h01);
        expect_frame(2, 2, 32'h0200_0201, 8'h01);
`endif
        fork
            begin
                send_frame(0, 2, 32'hEE00_0000, 8'h01);
                send_frame(0, 2, 32'hEE00_0001, 8'h01);
            end
            begin
                send_frame(2, 2, 32'hEE00_0200, 8'h01);
                send_frame(2, 2, 32'hEE00_0201, 8'h01);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        compare_queues("contend");

        // Downstream stall mid-frame: the buffered word must hold steady
        expect_frame(3, 4, 32'h0334_5678, 8'h10);
        fork
            send_frame(3, 4, 32'h1234_5678, 8'h10);
            begin
                g = 0;
                while (obs_q.size() < 1 && g < 100) begin
                    @(posedge clk);
                    g++;
                end
                #1;
                bus.smiReqStop = 1'b1;
                g = 0;
                @(negedge clk);
                while (!bus.smiReqReady && g < 20) begin
                    @(negedge clk);
                    g++;
                end
                for (int c = 0; c < 10; c++) begin
                    check($sformatf("hold%0d_ready", c), 64'(bus.smiReqReady), 64'd1);
                    check($sformatf("hold%0d_data", c), 64'(bus.smiReqData), 64'(body_word(3, 1)));
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                bus.smiReqStop = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        compare_queues("hold");

        // Reset while port 1 is mid-frame
        bus.portReqReady[1]    = 1'b1;
        bus.portReqData[DW +: DW] = 32'h5500_0001;
        bus.portReqEofc[8 +: 8] = 8'h00;
        g  = 0;
        go = 1'b0;
        while (!go && g < 20) begin
            @(negedge clk);
            go = !bus.portReqStop[1];
            @(posedge clk);
            #1;
            g++;
        end
        check("rst_mid_hdr_accept", 64'(go), 64'd1);
        check("rst_mid_in_body", 64'(bus.dbgArbState), 64'd2);
        bus.portReqData[DW +: DW] = body_word(1, 1);
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        bus.portReqReady[1] = 1'b0;
        @(negedge clk);
        check("rst_mid_port_stop", 64'(bus.portReqStop), 64'hF);
        check("rst_mid_smi_ready", 64'(bus.smiReqReady), 64'd0);
        check("rst_mid_state", 64'(bus.dbgArbState), 64'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_eofc_q.delete();
        obs_q.delete();
        obs_eofc_q.delete();
        obs_cyc_q.delete();
        expect_frame(0, 1, 32'h0000_0A0A, 8'h01);
        expect_frame(3, 1, 32'h0300_0B0B, 8'h01);
        fork
            send_frame(0, 1, 32'h9900_0A0A, 8'h01);
            send_frame(3, 1, 32'h9900_0B0B, 8'h01);
        join
        repeat (3) @(posedge clk);
        #1;
        compare_queues("after_rst");

        // Single-word response frames from the table
        for (int v = 0; v < 6; v++) begin
            send_resp(rv[v].data, rv[v].eofc);
            @(negedge clk);
            check($sformatf("resp%0d_ready", v), 64'(bus.portRespReady), 64'(rv[v].exp_ready));
            check($sformatf("resp%0d_stop", v), 64'(bus.smiRespStop), 64'(rv[v].exp_ready != 4'd0));
            for (int p = 0; p < NP; p++) begin
                if (rv[v].exp_ready[p]) begin
                    check($sformatf("resp%0d_data", v), 64'(bus.portRespData[p*DW +: DW]), 64'(rv[v].exp_data));
                    check($sformatf("resp%0d_eofc", v), 64'(bus.portRespEofc[p*8 +: 8]), 64'(rv[v].eofc));
                end
            end
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("resp%0d_done", v), 64'(bus.portRespReady), 64'd0);
            @(posedge clk);
            #1;
        end

        // Two-word response to port 1 under port backpressure
        bus.portRespStop = 4'b0010;
        send_resp(32'h01FF_0000, 8'h00);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d_ready", c), 64'(bus.portRespReady), 64'b0010);
            check($sformatf("bp%0d_data", c), 64'(bus.portRespData[DW +: DW]), 64'h00FF_0000);
            check($sformatf("bp%0d_stop", c), 64'(bus.smiRespStop), 64'd1);
            @(posedge clk);
            #1;
        end
        bus.portRespStop = 4'b0000;
        send_resp(32'h0000_0033, 8'h02);
        @(negedge clk);
        check("bp_body_ready", 64'(bus.portRespReady), 64'b0010);
        check("bp_body_data", 64'(bus.portRespData[DW +: DW]), 64'h0000_0033);
        check("bp_body_eofc", 64'(bus.portRespEofc[8 +: 8]), 64'h02);
        @(posedge clk);
        #1;

        // Two-word frame to route 6 is swallowed whole
        send_resp(32'h0600_0000, 8'h00);
        @(negedge clk);
        check("drop_hdr_ready", 64'(bus.portRespReady), 64'd0);
        @(posedge clk);
        #1;
        send_resp(32'h0000_0009, 8'h01);
        @(negedge clk);
        check("drop_body_ready", 64'(bus.portRespReady), 64'd0);
        check("drop_body_stop", 64'(bus.smiRespStop), 64'd0);
        @(posedge clk);
        #1;

        // Next frame starts a fresh route
        send_resp(32'h0200_0001, 8'h01);
        @(negedge clk);
        check("after_drop_ready", 64'(bus.portRespReady), 64'b0100);
        check("after_drop_data", 64'(bus.portRespData[2*DW +: DW]), 64'h0000_0001);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
